temp_sense_avg: RTL and testbench
=================================

// Module: temp_sense_avg
// PURPOSE
//  Periodic die-temperature monitor for the on-chip temperature sensor macro. It pulses the macro clear,
//  waits for conversion done, and captures each reading. It then box-averages 2**AVG_LOG2 readings and
//  drives the averaged value, a valid strobe, a hysteresis over-temperature alarm and a timeout flag.
//  Successor to the fixed 8-bit single-shot wrapper. Sensor macro is instantiated outside, on clk.
// PARAMETERS
//  DW        8     sensor/result width (bits)
//  AVG_LOG2  2     log2 of samples per average (0 = no averaging)
//  CLR_CYC   8     ts_clr pulse length, clk cycles (>=1)
//  PERIOD    4800  clk cycles from one conversion start to the next (> CLR_CYC+TIMEOUT)
//  TIMEOUT   1024  max clk cycles waiting for ts_done before abort
//  TH_HI     8'd100 alarm set threshold (DW bits)
//  HYST      8'd5  alarm clear hysteresis; alarm clears below TH_HI-HYST (HYST<=TH_HI)
// PORTS
//  clk          in   1   sole clock
//  clr          in   1   async active-high reset
//  en           in   1   run enable; low = idle
//  ts_clr       out  1   clear/start to sensor macro
//  ts_done      in   1   sensor conversion-done level
//  ts_data      in   DW  sensor reading, valid while ts_done high
//  data         out  DW  last averaged temperature
//  data_valid   out  1   one-cycle strobe, data updated
//  alarm        out  1   over-temperature, hysteretic
//  timeout_err  out  1   last conversion timed out
// BEHAVIOUR
//  Reset (clr=1, async): FSM=IDLE; ts_clr=1; data=0; data_valid=0; alarm=0; timeout_err=0; acc/count=0.
//  FSM: IDLE -(en)-> CLEAR; CLEAR holds ts_clr=1 for CLR_CYC cycles -> CONV.
//   CONV: ts_clr=0. Sample accepted on ts_done rising edge (registered previous value); ts_data captured
//   that cycle -> ACC. No edge within TIMEOUT cycles -> timeout_err=1, sample discarded -> WAIT.
//   ACC (1 cycle): acc+=sample, count++ -> WAIT. WAIT: until PERIOD counter (started at CLEAR entry) expires -> CLEAR.
//  Average: acc width DW+AVG_LOG2, no overflow possible. When count reaches 2**AVG_LOG2, the ACC cycle
//   writes data=(acc+sample)>>AVG_LOG2 (truncate) and pulses data_valid the next cycle. It also clears acc/count.
//  Alarm updated only with data_valid: set if new data>=TH_HI; clear if new data<TH_HI-HYST; else hold.
//  timeout_err: set on timeout; cleared on next accepted sample; also cleared by clr.
//  en low in any state: next cycle FSM=IDLE, ts_clr=1, acc/count cleared (partial average dropped);
//   data, alarm, timeout_err hold. en high again restarts at CLEAR with fresh period.
//  ts_done already high on CONV entry is not an edge; wait for low->high.
//  ts_done edge in the same cycle as timeout expiry: sample accepted, no timeout.
//  clr mid-conversion: all state to reset values immediately; no data_valid.
// CONFIGURATION
//  TEMP_MINMAX_EN defined: extra outputs tmin, tmax (DW each), reset tmin=all-ones, tmax=0. They update on
//   each data_valid with min/max of data and clear only on clr. Undefined: ports and logic absent.
// STRUCTURE
//  Package temp_sense_pkg: FSM state enum (IDLE,CLEAR,CONV,ACC,WAIT), counter width function (clog2),
//   default DW/threshold constants shared with other temp_sense blocks.
//  Sub-module temp_sense_acc: accumulator, sample counter, shift/divide, data_valid; FSM stays in top.
// TESTING
//  1 AVG_LOG2=2, readings 100,101,102,103 -> one data_valid, data=101, alarm=1 after 4th sample.
//  2 Then readings 96x4 -> data=96, alarm holds 1; readings 94x4 -> data=94, alarm=0.
//  3 Sensor never raises ts_done -> timeout_err=1 exactly TIMEOUT cycles after CONV entry; next good sample clears it.
//  4 en dropped after 2 of 4 samples, re-raised -> ts_clr reasserts; next data_valid needs 4 fresh samples.
//  5 ts_done held high across CLEAR -> no sample accepted until it falls and rises again.
//  6 TEMP_MINMAX_EN, averages 60,90,75 -> tmin=60, tmax=90; clr mid-CONV -> all outputs reset values.

Source files
------------

// File: rtl/temp_sense_pkg.sv
// temp_sense_pkg: FSM states, shared default constants and counter sizing for the temp_sense blocks
package temp_sense_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, CONV, ACC, WAIT} ts_state_e;
  localparam int TS_DW = 8;
  localparam logic [7:0] TS_TH_HI = 8'd100;
  localparam logic [7:0] TS_HYST = 8'd5;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/temp_sense_acc.sv
// temp_sense_acc: box-average accumulator; loads data and strobes valid every 2**AVG_LOG2 samples
module temp_sense_acc
  import temp_sense_pkg::*;
#(
  parameter int DW = TS_DW,
  parameter int AVG_LOG2 = 2
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          flush_i,
  input  logic          add_i,
  input  logic [DW-1:0] smp_i,
  output logic [DW-1:0] data_o,
  output logic          dv_o,
  output logic          ld_o,
  output logic [DW-1:0] avg_o
);
  localparam int AW = DW + AVG_LOG2;
  localparam int CW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);
  logic [AW-1:0] acc_q, acc_d, sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] data_q, data_d;
  logic dv_q;
  always_comb begin
    sum = acc_q + AW'(smp_i);
    ld_o = add_i && !flush_i && cnt_q == CNT_LAST;
    avg_o = DW'(sum >> AVG_LOG2);
    acc_d = (flush_i || ld_o) ? '0 : add_i ? sum : acc_q;
    cnt_d = (flush_i || ld_o) ? '0 : add_i ? cnt_q + 1'b1 : cnt_q;
    data_d = ld_o ? avg_o : data_q;
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      acc_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      dv_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      dv_q <= ld_o;
    end
  assign data_o = data_q;
  assign dv_o = dv_q;
endmodule

// File: rtl/temp_sense_avg.sv
// temp_sense_avg: periodic sensor sampler with box averaging, hysteretic alarm and timeout flag.
// Define TEMP_MINMAX_EN to add running tmin/tmax outputs.
module temp_sense_avg
  import temp_sense_pkg::*;
#(
  parameter int DW = TS_DW,
  parameter int AVG_LOG2 = 2,
  parameter int CLR_CYC = 8,
  parameter int PERIOD = 4800,
  parameter int TIMEOUT = 1024,
  parameter logic [DW-1:0] TH_HI = DW'(TS_TH_HI),
  parameter logic [DW-1:0] HYST = DW'(TS_HYST)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  output logic          ts_clr,
  input  logic          ts_done,
  input  logic [DW-1:0] ts_data,
  output logic [DW-1:0] data,
  output logic          data_valid,
  output logic          alarm,
  output logic          timeout_err
`ifdef TEMP_MINMAX_EN
  ,
  output logic [DW-1:0] tmin,
  output logic [DW-1:0] tmax
`endif
);
  localparam int PW = cnt_w(PERIOD);
  localparam logic [PW-1:0] CLR_LAST = PW'(CLR_CYC - 1);
  localparam logic [PW-1:0] TMO_LAST = PW'(CLR_CYC + TIMEOUT - 1);
  localparam logic [PW-1:0] PER_LAST = PW'(PERIOD - 1);
  localparam logic [DW-1:0] TH_LO = TH_HI - HYST;
  ts_state_e state_q, state_d;
  logic [PW-1:0] per_q, per_d;
  logic [DW-1:0] smp_q, smp_d, avg;
  logic done_q, tmo_q, tmo_d, alarm_q, alarm_d;
  logic rise, tmo_hit, take, add, flush, ld;
  assign rise = ts_done & ~done_q;
  assign tmo_hit = per_q == TMO_LAST;
  assign take = en && state_q == CONV && rise;
  always_ff @(posedge clk or posedge clr)
    if (clr) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = CLEAR;
      CLEAR:     state_d = per_q == CLR_LAST ? CONV : CLEAR;
      CONV:      state_d = rise ? ACC : tmo_hit ? WAIT : CONV;
      ACC, WAIT: state_d = per_q == PER_LAST ? CLEAR : WAIT;
      default:   state_d = IDLE;
    endcase
    if (!en) state_d = IDLE;
  end
  always_comb begin
    ts_clr = state_q == IDLE || state_q == CLEAR;
    add = en && state_q == ACC;
    flush = !en;
  end
  // period counter restarts on every CLEAR entry; timeout is measured on the same count
  always_comb begin
    per_d = (state_q == IDLE || (state_d == CLEAR && state_q != CLEAR)) ? '0 : per_q + 1'b1;
    smp_d = take ? ts_data : smp_q;
    tmo_d = take ? 1'b0 : (en && state_q == CONV && tmo_hit) ? 1'b1 : tmo_q;
    alarm_d = !ld ? alarm_q : avg >= TH_HI ? 1'b1 : avg < TH_LO ? 1'b0 : alarm_q;
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      per_q <= '0;
      smp_q <= '0;
      done_q <= 1'b0;
      tmo_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      per_q <= per_d;
      smp_q <= smp_d;
      done_q <= ts_done;
      tmo_q <= tmo_d;
      alarm_q <= alarm_d;
    end
  temp_sense_acc #(.DW(DW), .AVG_LOG2(AVG_LOG2)) u_acc (
    .clk(clk),
    .clr(clr),
    .flush_i(flush),
    .add_i(add),
    .smp_i(smp_q),
    .data_o(data),
    .dv_o(data_valid),
    .ld_o(ld),
    .avg_o(avg)
  );
  assign alarm = alarm_q;
  assign timeout_err = tmo_q;
`ifdef TEMP_MINMAX_EN
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      tmin <= '1;
      tmax <= '0;
    end else if (ld) begin
      tmin <= avg < tmin ? avg : tmin;
      tmax <= avg > tmax ? avg : tmax;
    end
`endif
endmodule

// File: tb/tb_temp_sense_avg.sv
// tb_temp_sense_avg: randomized bench for temp_sense_avg; expected averages come from a sample queue model.
module tb_temp_sense_avg;
  localparam int DW = 8, N = 4, CLR_CYC = 4, PERIOD = 200, TIMEOUT = 64;
  logic clk = 1'b0, clr = 1'b1, en = 1'b0, ts_done = 1'b0;
  logic [DW-1:0] ts_data = '0;
  logic ts_clr, data_valid, alarm, timeout_err;
  logic [DW-1:0] data;
  int ntest = 0, nfail = 0, dv_cnt = 0, exp_dv = 0;
  int pend[$];
  logic [DW-1:0] exp_data = '0;
  logic exp_alarm = 1'b0;
`ifdef TEMP_MINMAX_EN
  logic [DW-1:0] tmin, tmax;
  logic [DW-1:0] exp_min = '1, exp_max = '0;
`endif

  temp_sense_avg #(.CLR_CYC(CLR_CYC), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clr(clr), .en(en), .ts_clr(ts_clr), .ts_done(ts_done), .ts_data(ts_data),
    .data(data), .data_valid(data_valid), .alarm(alarm), .timeout_err(timeout_err)
`ifdef TEMP_MINMAX_EN
    , .tmin(tmin), .tmax(tmax)
`endif
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (data_valid === 1'b1) dv_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: every N accepted readings average to their integer mean; alarm uses 100 / 95 thresholds.
  task automatic push_sample(input logic [DW-1:0] v);
    int s;
    pend.push_back(int'(v));
    if (pend.size() == N) begin
      s = 0;
      foreach (pend[i]) s += pend[i];
      exp_data = DW'(s / N);
      exp_alarm = exp_data >= 100 ? 1'b1 : exp_data < 95 ? 1'b0 : exp_alarm;
      exp_dv++;
`ifdef TEMP_MINMAX_EN
      if (exp_data < exp_min) exp_min = exp_data;
      if (exp_data > exp_max) exp_max = exp_data;
`endif
      pend.delete();
    end
  endtask

  task automatic wait_conv();
    logic p;
    p = ts_clr;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      if (p && !ts_clr) return;
      p = ts_clr;
    end
    ntest++;
    nfail++;
    $display("FAIL wait_conv: ts_clr never fell within %0d cycles", 3 * PERIOD);
  endtask

  task automatic sample(input logic [DW-1:0] v, input int dly);
    wait_conv();
    repeat (dly) @(negedge clk);
    ts_data = v;
    ts_done = 1'b1;
    repeat (2) @(negedge clk);
    ts_done = 1'b0;
    push_sample(v);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    ntest++; if (ts_clr !== 1'b1) begin nfail++; $display("FAIL reset_ts_clr got %b want 1", ts_clr); end
    ntest++; if (data !== '0) begin nfail++; $display("FAIL reset_data got %0d want 0", data); end
    ntest++; if (data_valid !== 1'b0) begin nfail++; $display("FAIL reset_dv got %b want 0", data_valid); end
    ntest++; if (alarm !== 1'b0) begin nfail++; $display("FAIL reset_alarm got %b want 0", alarm); end
    ntest++; if (timeout_err !== 1'b0) begin nfail++; $display("FAIL reset_tmo got %b want 0", timeout_err); end
    clr = 1'b0;
    en = 1'b1;
  endtask

  task automatic test_avg_alarm();
    logic [DW-1:0] seq [12] = '{8'd100, 8'd101, 8'd102, 8'd103, 8'd96, 8'd96, 8'd96, 8'd96, 8'd94, 8'd94, 8'd94, 8'd94};
    for (int i = 0; i < 12; i++) begin
      sample(seq[i], $urandom_range(0, 10));
      repeat (3) @(negedge clk);
      if (i % 4 == 2) begin
        ntest++; if (dv_cnt !== exp_dv) begin nfail++; $display("FAIL avg_early_dv got %0d want %0d", dv_cnt, exp_dv); end
      end
      if (i % 4 == 3) begin
        ntest++; if (dv_cnt !== exp_dv) begin nfail++; $display("FAIL avg_dv_count got %0d want %0d", dv_cnt, exp_dv); end
        ntest++; if (data !== exp_data) begin nfail++; $display("FAIL avg_data got %0d want %0d", data, exp_data); end
        ntest++; if (alarm !== exp_alarm) begin nfail++; $display("FAIL avg_alarm got %b want %b", alarm, exp_alarm); end
      end
    end
  endtask

  task automatic test_timeout();
    wait_conv();
    repeat (TIMEOUT - 1) @(negedge clk);
    ntest++; if (timeout_err !== 1'b0) begin nfail++; $display("FAIL tmo_early got %b want 0", timeout_err); end
    @(negedge clk);
    ntest++; if (timeout_err !== 1'b1) begin nfail++; $display("FAIL tmo_set got %b want 1", timeout_err); end
    sample(8'($urandom_range(80, 120)), $urandom_range(0, 10));
    ntest++; if (timeout_err !== 1'b0) begin nfail++; $display("FAIL tmo_clear got %b want 0", timeout_err); end
  endtask

  task automatic test_en_drop();
    sample(8'($urandom_range(80, 120)), $urandom_range(0, 10));
    en = 1'b0;
    pend.delete();
    @(negedge clk);
    ntest++; if (ts_clr !== 1'b1) begin nfail++; $display("FAIL en_drop_ts_clr got %b want 1", ts_clr); end
    repeat (5) @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < N; i++) begin
      sample(8'($urandom_range(80, 120)), $urandom_range(0, 10));
      repeat (3) @(negedge clk);
      ntest++; if (dv_cnt !== exp_dv) begin nfail++; $display("FAIL en_drop_dv got %0d want %0d", dv_cnt, exp_dv); end
    end
    ntest++; if (data !== exp_data) begin nfail++; $display("FAIL en_drop_data got %0d want %0d", data, exp_data); end
    ntest++; if (alarm !== exp_alarm) begin nfail++; $display("FAIL en_drop_alarm got %b want %b", alarm, exp_alarm); end
  endtask

  task automatic test_held_high();
    ts_data = 8'd200;
    ts_done = 1'b1;
    wait_conv();
    repeat (3) @(negedge clk);
    ts_done = 1'b0;
    repeat (2) @(negedge clk);
    ts_data = 8'd90;
    ts_done = 1'b1;
    repeat (2) @(negedge clk);
    ts_done = 1'b0;
    push_sample(8'd90);
    for (int i = 1; i < N; i++) sample(8'd90, $urandom_range(0, 10));
    repeat (3) @(negedge clk);
    ntest++; if (dv_cnt !== exp_dv) begin nfail++; $display("FAIL held_dv got %0d want %0d", dv_cnt, exp_dv); end
    ntest++; if (data !== exp_data) begin nfail++; $display("FAIL held_data got %0d want %0d", data, exp_data); end
    ntest++; if (alarm !== exp_alarm) begin nfail++; $display("FAIL held_alarm got %b want %b", alarm, exp_alarm); end
  endtask

  task automatic test_random();
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < N; i++) sample(8'($urandom_range(85, 115)), $urandom_range(0, 12));
      repeat (3) @(negedge clk);
      ntest++; if (dv_cnt !== exp_dv) begin nfail++; $display("FAIL rand_dv g%0d got %0d want %0d", g, dv_cnt, exp_dv); end
      ntest++; if (data !== exp_data) begin nfail++; $display("FAIL rand_data g%0d got %0d want %0d", g, data, exp_data); end
      ntest++; if (alarm !== exp_alarm) begin nfail++; $display("FAIL rand_alarm g%0d got %b want %b", g, alarm, exp_alarm); end
    end
  endtask

  task automatic test_clr_mid();
    for (int i = 0; i < N; i++) sample(8'd110, $urandom_range(0, 10));
    wait_conv();
    repeat (TIMEOUT + 1) @(negedge clk);
    ntest++; if (timeout_err !== 1'b1) begin nfail++; $display("FAIL clr_pre_tmo got %b want 1", timeout_err); end
    wait_conv();
    repeat (3) @(negedge clk);
    clr = 1'b1;
    pend.delete();
    exp_data = '0;
    exp_alarm = 1'b0;
`ifdef TEMP_MINMAX_EN
    exp_min = '1;
    exp_max = '0;
`endif
    #1;
    ntest++; if (ts_clr !== 1'b1) begin nfail++; $display("FAIL clr_ts_clr got %b want 1", ts_clr); end
    ntest++; if (data !== exp_data) begin nfail++; $display("FAIL clr_data got %0d want %0d", data, exp_data); end
    ntest++; if (alarm !== 1'b0) begin nfail++; $display("FAIL clr_alarm got %b want 0", alarm); end
    ntest++; if (timeout_err !== 1'b0) begin nfail++; $display("FAIL clr_tmo got %b want 0", timeout_err); end
`ifdef TEMP_MINMAX_EN
    ntest++; if (tmin !== exp_min) begin nfail++; $display("FAIL clr_tmin got %0d want %0d", tmin, exp_min); end
    ntest++; if (tmax !== exp_max) begin nfail++; $display("FAIL clr_tmax got %0d want %0d", tmax, exp_max); end
`endif
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);
    ntest++; if (dv_cnt !== exp_dv) begin nfail++; $display("FAIL clr_dv got %0d want %0d", dv_cnt, exp_dv); end
  endtask

`ifdef TEMP_MINMAX_EN
  task automatic test_minmax();
    logic [DW-1:0] lvl [3] = '{8'd60, 8'd90, 8'd75};
    for (int g = 0; g < 3; g++)
      for (int i = 0; i < N; i++) sample(lvl[g], $urandom_range(0, 10));
    repeat (3) @(negedge clk);
    ntest++; if (tmin !== exp_min) begin nfail++; $display("FAIL mm_tmin got %0d want %0d", tmin, exp_min); end
    ntest++; if (tmax !== exp_max) begin nfail++; $display("FAIL mm_tmax got %0d want %0d", tmax, exp_max); end
    ntest++; if (data !== exp_data) begin nfail++; $display("FAIL mm_data got %0d want %0d", data, exp_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_avg_alarm();
    test_timeout();
    test_en_drop();
    test_held_high();
    test_random();
    test_clr_mid();
`ifdef TEMP_MINMAX_EN
    test_minmax();
`endif
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
